// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path:
// opcodes, ALU operations, ALU B-operand selects, FSM states and the
// per-state Moore control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b000111;
  localparam logic [5:0] OP_SLTI  = 6'b000001;
  localparam logic [5:0] OP_BEQ   = 6'b000110;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_ILLEGAL  = 4'd12,
    S_ERROR    = 4'd13
  } state_e;

  // Control bits that depend only on the state (plus opcode for addi/slti).
  // Strobes gated by memReady are built separately in the top.
  typedef struct packed {
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       pc_source;
    logic       retire;
    logic       illegal;
    logic       error;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(input state_e st, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMMSH;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_RT;
        c.alu_op    = ALU_FUNCT;
      end
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_WB_I: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      S_WB_MEM: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
        c.retire        = 1'b1;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      S_ERROR:   c.error   = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memReady-low cycles in a memory state and flags when the
// count has reached the limit. MEM_TIMEOUT = 0 disables the flag.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic TIMER_ON = (MEM_TIMEOUT > 0);

  logic [WAIT_W-1:0] wait_cnt_r;

  // Wait counter: cleared on every state change, saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
    end else if (clear) begin
      wait_cnt_r <= '0;
    end else if (enable && (wait_cnt_r != LIMIT)) begin
      wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout = TIMER_ON && (wait_cnt_r == LIMIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the MIPS-subset datapath. Moore control word
// is registered from the next state; irWrite/pcWrite in FETCH and the
// store-completion retire pulse are qualified by memReady.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [5:0]       opCode,
  input  logic             zero,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             iorD,
  output logic             irWrite,
  output logic             memRead,
  output logic             memWrite,
  output logic             memToReg,
  output logic             regDestination,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [2:0]       aluOpcode,
  output logic             pcSource,
  output logic             instrRetired,
  output logic             illegalOp,
  output logic             error,
  output logic [CNT_W-1:0] retiredCount
);

  state_e           state_r;
  state_e           nxt_state_s;
  ctrl_t            ctrl_r;
  logic [CNT_W-1:0] retired_count_r;
  logic             in_mem_s;
  logic             timeout_s;
  logic             fetch_done_s;
  logic             retire_s;
  logic             unused_zero;

  // The zero flag gates the PC load in the datapath, not the sequencing.
  assign unused_zero = zero;

  assign in_mem_s     = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
  assign fetch_done_s = (state_r == S_FETCH) && memReady;
  assign retire_s     = ctrl_r.retire || ((state_r == S_MEM_WR) && memReady);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rstN),
    .clear   (nxt_state_s != state_r),
    .enable  (in_mem_s && !memReady),
    .timeout (timeout_s)
  );

  // Next-state selection; memory states leave on memReady or on timeout.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      S_IDLE:   nxt_state_s = S_FETCH;
      S_FETCH: begin
        if (memReady)       nxt_state_s = S_DECODE;
        else if (timeout_s) nxt_state_s = S_ERROR;
        else                nxt_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (opCode)
          OP_RTYPE:        nxt_state_s = S_EXEC_R;
          OP_LW, OP_SW:    nxt_state_s = S_MEM_ADDR;
          OP_ADDI, OP_SLTI: nxt_state_s = S_EXEC_I;
          OP_BEQ:          nxt_state_s = S_BRANCH;
          default:         nxt_state_s = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   nxt_state_s = S_WB_R;
      S_WB_R:     nxt_state_s = S_FETCH;
      S_EXEC_I:   nxt_state_s = S_WB_I;
      S_WB_I:     nxt_state_s = S_FETCH;
      S_MEM_ADDR: nxt_state_s = (opCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (memReady)       nxt_state_s = S_WB_MEM;
        else if (timeout_s) nxt_state_s = S_ERROR;
        else                nxt_state_s = S_MEM_RD;
      end
      S_WB_MEM:   nxt_state_s = S_FETCH;
      S_MEM_WR: begin
        if (memReady)       nxt_state_s = S_FETCH;
        else if (timeout_s) nxt_state_s = S_ERROR;
        else                nxt_state_s = S_MEM_WR;
      end
      S_BRANCH:   nxt_state_s = S_FETCH;
      S_ILLEGAL:  nxt_state_s = S_FETCH;
      S_ERROR:    nxt_state_s = S_ERROR;
      default:    nxt_state_s = S_IDLE;
    endcase
  end

  // State, registered control word and retired-instruction counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r         <= S_IDLE;
      ctrl_r          <= '0;
      retired_count_r <= '0;
    end else begin
      state_r <= nxt_state_s;
      ctrl_r  <= ctrl_decode(nxt_state_s, opCode);
      if (retire_s) begin
        retired_count_r <= retired_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_count_r <= retired_count_r;
      end
    end
  end

  assign pcWrite        = fetch_done_s;
  assign irWrite        = fetch_done_s;
  assign pcWriteCond    = ctrl_r.pc_write_cond;
  assign iorD           = ctrl_r.ior_d;
  assign memRead        = ctrl_r.mem_read;
  assign memWrite       = ctrl_r.mem_write;
  assign memToReg       = ctrl_r.mem_to_reg;
  assign regDestination = ctrl_r.reg_dst;
  assign regWrite       = ctrl_r.reg_write;
  assign aluSrcA        = ctrl_r.alu_src_a;
  assign aluSrcB        = ctrl_r.alu_src_b;
  assign aluOpcode      = ctrl_r.alu_op;
  assign pcSource       = ctrl_r.pc_source;
  assign instrRetired   = retire_s;
  assign illegalOp      = ctrl_r.illegal;
  assign error          = ctrl_r.error;
  assign retiredCount   = retired_count_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with MEM_TIMEOUT=4, CNT_W=4.
module tb_multicycle_control_fsm;

  localparam int TB_CNT_W = 4;

  typedef enum int {
    T_IDLE, T_FETCH, T_DECODE, T_EXEC_R, T_WB_R, T_EXEC_I, T_WB_I,
    T_MEM_ADDR, T_MEM_RD, T_WB_MEM, T_MEM_WR, T_BRANCH, T_ILLEGAL, T_ERROR
  } tstate_e;

  logic                clk;
  logic                rstN;
  logic [5:0]          opCode;
  logic                zero;
  logic                memReady;
  logic                pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite;
  logic                memToReg, regDestination, regWrite, aluSrcA, pcSource;
  logic                instrRetired, illegalOp, error;
  logic [1:0]          aluSrcB;
  logic [2:0]          aluOpcode;
  logic [TB_CNT_W-1:0] retiredCount;

  int                  n_tests;
  int                  n_fail;
  logic [TB_CNT_W-1:0] exp_cnt;
  logic [18:0]         obs;

  multicycle_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rstN(rstN), .opCode(opCode), .zero(zero), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .irWrite(irWrite),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .regDestination(regDestination), .regWrite(regWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOpcode(aluOpcode), .pcSource(pcSource),
    .instrRetired(instrRetired), .illegalOp(illegalOp), .error(error),
    .retiredCount(retiredCount)
  );

  assign obs = {pcWrite, pcWriteCond, iorD, irWrite, memRead, memWrite, memToReg,
                regDestination, regWrite, aluSrcA, aluSrcB, aluOpcode, pcSource,
                instrRetired, illegalOp, error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hand-written expected control vector for each state.
  function automatic logic [18:0] exp_vec(input tstate_e s, input logic rdy, input logic [5:0] op);
    logic pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rwr, sa, pcs, ret, ill, err;
    logic [1:0] sb;
    logic [2:0] aop;
    {pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rwr, sa, pcs, ret, ill, err} = 14'd0;
    sb = 2'b00;
    aop = 3'b000;
    case (s)
      T_FETCH:    begin mrd = 1'b1; sb = 2'b01; aop = 3'b011; pcw = rdy; irw = rdy; end
      T_DECODE:   begin sb = 2'b11; aop = 3'b011; end
      T_EXEC_R:   begin sa = 1'b1; sb = 2'b00; aop = 3'b000; end
      T_WB_R:     begin rdst = 1'b1; rwr = 1'b1; ret = 1'b1; end
      T_EXEC_I:   begin sa = 1'b1; sb = 2'b10; aop = (op == 6'b000001) ? 3'b010 : 3'b011; end
      T_WB_I:     begin rwr = 1'b1; ret = 1'b1; end
      T_MEM_ADDR: begin sa = 1'b1; sb = 2'b10; aop = 3'b011; end
      T_MEM_RD:   begin mrd = 1'b1; iord = 1'b1; end
      T_WB_MEM:   begin m2r = 1'b1; rwr = 1'b1; ret = 1'b1; end
      T_MEM_WR:   begin mwr = 1'b1; iord = 1'b1; ret = rdy; end
      T_BRANCH:   begin sa = 1'b1; sb = 2'b00; aop = 3'b001; pwc_set(pcwc); pcs = 1'b1; ret = 1'b1; end
      T_ILLEGAL:  ill = 1'b1;
      T_ERROR:    err = 1'b1;
      default:    ;
    endcase
    return {pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rwr, sa, sb, aop, pcs, ret, ill, err};
  endfunction

  function automatic void pwc_set(output logic b);
    b = 1'b1;
  endfunction

  // One clock cycle in expected state s: drive memReady, check outputs and
  // the counter, then advance past the next rising edge.
  task automatic cyc(input string tag, input tstate_e s, input logic rdy);
    logic [18:0] e;
    memReady = rdy;
    #1;
    e = exp_vec(s, rdy, opCode);
    check({tag, "_ctrl"}, {13'd0, obs}, {13'd0, e});
    check({tag, "_cnt"}, {28'd0, retiredCount}, {28'd0, exp_cnt});
    @(posedge clk);
    #2;
    if (e[2]) exp_cnt = exp_cnt + 4'd1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_cnt  = 4'd0;
    rstN     = 1'b0;
    memReady = 1'b0;
    opCode   = 6'b000000;
    zero     = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    memReady = 1'b1;
    #1;
    check("reset_ctrl", {13'd0, obs}, 32'd0);
    check("reset_cnt", {28'd0, retiredCount}, 32'd0);
    rstN = 1'b1;

    // R-type
    opCode = 6'b000000;
    cyc("r_idle", T_IDLE, 1'b1);
    cyc("r_fetch", T_FETCH, 1'b1);
    cyc("r_dec", T_DECODE, 1'b1);
    cyc("r_exec", T_EXEC_R, 1'b1);
    cyc("r_wb", T_WB_R, 1'b1);
    check("r_count", {28'd0, retiredCount}, 32'd1);

    // lw with three wait states in MEM_RD
    opCode = 6'b000100;
    cyc("lw_fetch", T_FETCH, 1'b1);
    cyc("lw_dec", T_DECODE, 1'b1);
    cyc("lw_addr", T_MEM_ADDR, 1'b1);
    for (int i = 0; i < 3; i++) cyc("lw_wait", T_MEM_RD, 1'b0);
    cyc("lw_rd", T_MEM_RD, 1'b1);
    cyc("lw_wb", T_WB_MEM, 1'b1);

    // sw with one wait state
    opCode = 6'b000101;
    cyc("sw_fetch", T_FETCH, 1'b1);
    cyc("sw_dec", T_DECODE, 1'b1);
    cyc("sw_addr", T_MEM_ADDR, 1'b1);
    cyc("sw_wait", T_MEM_WR, 1'b0);
    cyc("sw_wr", T_MEM_WR, 1'b1);

    // beq
    opCode = 6'b000110;
    cyc("beq_fetch", T_FETCH, 1'b1);
    cyc("beq_dec", T_DECODE, 1'b1);
    cyc("beq_br", T_BRANCH, 1'b1);

    // slti
    opCode = 6'b000001;
    cyc("slti_fetch", T_FETCH, 1'b1);
    cyc("slti_dec", T_DECODE, 1'b1);
    cyc("slti_exec", T_EXEC_I, 1'b1);
    cyc("slti_wb", T_WB_I, 1'b1);

    // illegal opcode: skipped, not counted
    opCode = 6'b111111;
    cyc("ill_fetch", T_FETCH, 1'b1);
    cyc("ill_dec", T_DECODE, 1'b1);
    cyc("ill_pulse", T_ILLEGAL, 1'b1);
    check("ill_count", {28'd0, retiredCount}, 32'd5);

    // addi with memReady arriving exactly at the wait limit
    opCode = 6'b000111;
    for (int i = 0; i < 4; i++) cyc("lim_wait", T_FETCH, 1'b0);
    cyc("lim_ok", T_FETCH, 1'b1);
    cyc("lim_dec", T_DECODE, 1'b1);
    cyc("lim_exec", T_EXEC_I, 1'b1);
    cyc("lim_wb", T_WB_I, 1'b1);

    // ten more addi: sixteen retirements wrap the 4-bit counter
    for (int k = 0; k < 10; k++) begin
      cyc("addi_fetch", T_FETCH, 1'b1);
      cyc("addi_dec", T_DECODE, 1'b1);
      cyc("addi_exec", T_EXEC_I, 1'b1);
      cyc("addi_wb", T_WB_I, 1'b1);
    end
    check("wrap_count", {28'd0, retiredCount}, 32'd0);
    cyc("add2_fetch", T_FETCH, 1'b1);
    cyc("add2_dec", T_DECODE, 1'b1);
    cyc("add2_exec", T_EXEC_I, 1'b1);
    cyc("add2_wb", T_WB_I, 1'b1);

    // reset asserted during MEM_WR
    opCode = 6'b000101;
    cyc("swr_fetch", T_FETCH, 1'b1);
    cyc("swr_dec", T_DECODE, 1'b1);
    cyc("swr_addr", T_MEM_ADDR, 1'b1);
    memReady = 1'b0;
    #1;
    check("swr_memwrite", {31'd0, memWrite}, 32'd1);
    rstN = 1'b0;
    #1;
    check("swr_abort_ctrl", {13'd0, obs}, 32'd0);
    check("swr_abort_cnt", {28'd0, retiredCount}, 32'd0);
    exp_cnt = 4'd0;
    @(posedge clk);
    #2;
    check("swr_hold_ctrl", {13'd0, obs}, 32'd0);
    rstN = 1'b1;

    // memory timeout in FETCH
    opCode = 6'b000111;
    cyc("to_idle", T_IDLE, 1'b0);
    for (int i = 0; i < 5; i++) cyc("to_wait", T_FETCH, 1'b0);
    for (int i = 0; i < 3; i++) cyc("to_err", T_ERROR, 1'b1);
    rstN = 1'b0;
    #1;
    check("to_reset", {13'd0, obs}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath: one shared memory, one ALU, instruction register.
- Replaces the single-cycle decoder; same opcode set and ALU op encoding.
- Steps each instruction through fetch/decode/execute/memory/writeback.
- Stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles in any memory state before ERROR; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rstN  input  1  asynchronous active-low reset
- opCode  input  6  instruction register bits [31:26]; valid from DECODE onward
- zero  input  1  ALU zero flag
- memReady  input  1  memory completed the current read/write this cycle
- pcWrite  output  1  unconditional PC load
- pcWriteCond  output  1  PC load if zero
- iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- irWrite  output  1  instruction register load
- memRead  output  1  memory read request
- memWrite  output  1  memory write request
- memToReg  output  1  writeback data select: 1 = MDR
- regDestination  output  1  1 = rd, 0 = rt
- regWrite  output  1  register file write
- aluSrcA  output  1  0 = PC, 1 = rs
- aluSrcB  output  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- aluOpcode  output  3  000 funct-driven, 011 add, 001 subtract, 010 set-less-than
- pcSource  output  1  0 = ALU result, 1 = ALUOut (branch target)
- instrRetired  output  1  one-cycle pulse on instruction completion
- illegalOp  output  1  one-cycle pulse on unknown opcode
- error  output  1  sticky memory-timeout flag
- retiredCount  output  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Outputs
  - Moore decode of the state register.
  - Exception: irWrite, pcWrite, instrRetired in memory states qualify with memReady, as noted below.
  - Control signals not listed for a state are 0.
- Reset
  - While rstN = 0: state = IDLE, every output 0, waitCnt = 0, retiredCount = 0, error = 0.
  - Reset asserted mid-instruction aborts it immediately; no partial write completes after assertion.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH
  - Asserts memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOpcode=011, pcSource=0.
  - On memReady: irWrite=1 and pcWrite=1 the same cycle, then DECODE.
  - Otherwise hold.
- DECODE
  - Asserts aluSrcA=0, aluSrcB=11, aluOpcode=011 (branch target into ALUOut).
  - Next state by opCode: 000000 EXEC_R; 000100/000101 MEM_ADDR; 000111/000001 EXEC_I; 000110 BRANCH; other ILLEGAL.
- EXEC_R: aluSrcA=1, aluSrcB=00, aluOpcode=000; next WB_R.
- WB_R: regDestination=1, regWrite=1, memToReg=0, instrRetired=1; next FETCH.
- EXEC_I: aluSrcA=1, aluSrcB=10, aluOpcode=011 (addi) or 010 (slti); next WB_I.
- WB_I: regDestination=0, regWrite=1, memToReg=0, instrRetired=1; next FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOpcode=011; next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: memRead=1, iorD=1; on memReady go to WB_MEM.
- WB_MEM: regDestination=0, memToReg=1, regWrite=1, instrRetired=1; next FETCH.
- MEM_WR: memWrite=1, iorD=1; on memReady instrRetired=1 and next FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOpcode=001, pcWriteCond=1, pcSource=1, instrRetired=1; next FETCH.
- ILLEGAL: illegalOp=1 for one cycle, no register or memory write, not counted as retired; next FETCH. The PC has already advanced, so the instruction is skipped.
- Memory wait timeout
  - waitCnt clears on entering FETCH, MEM_RD or MEM_WR, and increments each cycle memReady=0 in those states.
  - If MEM_TIMEOUT != 0 and waitCnt reaches MEM_TIMEOUT with memReady still 0: go to ERROR.
  - memReady in the same cycle as the limit counts as success.
- ERROR: all control outputs 0, error=1; held until reset.
- Counter: retiredCount increments on every instrRetired pulse and wraps from all-ones to 0.
- Cycle counts with zero wait states: R/addi/slti 4, lw 5, sw 4, beq 3, illegal 3.

Decomposition:
- Shared package `mips_ctrl_pkg`:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_SLTI)
  - ALU op constants (ALU_FUNCT, ALU_ADD, ALU_SUB, ALU_SLT)
  - aluSrcB select constants
  - state enum
- Sub-module `mem_wait_timer`: waitCnt, clear/enable, timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset, then R-type (opCode 000000), memReady tied 1 -> IDLE, FETCH, DECODE, EXEC_R, WB_R; regWrite=1 and regDestination=1 only in WB_R; retiredCount=1.
- lw (000100) with memReady low 3 cycles in MEM_RD -> memRead=1, iorD=1 held 4 cycles; WB_MEM with memToReg=1; total 8 cycles.
- beq (000110) -> BRANCH asserts pcWriteCond=1, pcSource=1, aluOpcode=001; no regWrite or memWrite at any point.
- opCode 111111 -> illegalOp pulses once; no write strobes; retiredCount unchanged; next cycle is FETCH.
- MEM_TIMEOUT=4, memReady stuck 0 in FETCH -> ERROR after 4 wait cycles; error=1 and all strobes 0 until rstN low.
- CNT_W=4, 16 addi (000111) -> retiredCount wraps to 0; rstN asserted during MEM_WR -> memWrite drops same cycle, outputs 0.
